// File: rtl/defs_pkg.sv
// Shared CPU definitions: control-unit states, control signal bundle and the
// fetch-stage state encoding used by fetch_unit.
package defs_pkg;

  typedef enum logic [3:0] {
    STATE_RESET,
    STATE_FETCH,
    STATE_DECODE,
    STATE_EXEC_ALU,
    STATE_EXEC_LOAD,
    STATE_EXEC_STORE,
    STATE_EXEC_JUMP,
    STATE_EXEC_BRANCH,
    STATE_EXEC_JR,
    STATE_EXEC_LINK,
    STATE_HALT
  } state_t;

  typedef struct packed {
    logic fetch_start;
    logic pc_redirect;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic link;
  } ctrl_sig_t;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DONE
  } fetch_state_t;

  localparam int unsigned RESET_PC = 0;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and instruction register, issues one
// word read per fetch_start over a req/ack handshake and applies PC redirects.
module fetch_unit
  import defs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned RESET_PC          = defs_pkg::RESET_PC
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         fetch_start,
  output logic                         fetch_done,
  output logic                         busy,
  output logic [INSTRUCTION_WIDTH-1:0] instruct,
  output logic [ADDR_WIDTH-1:0]        instr_pc,
  output logic [ADDR_WIDTH-1:0]        link_addr,
  output logic [ADDR_WIDTH-1:0]        pc,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_addr,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ack,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT  = ADDR_WIDTH'(RESET_PC);

  fetch_state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0] instruct_q, instruct_d;
  logic [ADDR_WIDTH-1:0]        instr_pc_q, instr_pc_d;
  logic [ADDR_WIDTH-1:0]        link_addr_q, link_addr_d;
  logic                         mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
  logic                         fetch_done_q, fetch_done_d;
  logic                         busy_q, busy_d;
  logic                         pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0]        pend_addr_q, pend_addr_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instruct_d   = instruct_q;
    instr_pc_d   = instr_pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fetch_done_d = 1'b0;
    pend_vld_d   = pend_vld_q;
    pend_addr_d  = pend_addr_q;

    unique case (state_q)
      FETCH_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_addr;
        end
        if (fetch_start) begin
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_valid ? redirect_addr : pc_q;
          state_d    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (mem_ack) begin
          instruct_d   = mem_rdata;
          instr_pc_d   = mem_addr_q;
          mem_req_d    = 1'b0;
          fetch_done_d = 1'b1;
          state_d      = FETCH_DONE;
          pend_vld_d   = 1'b0;
          // A redirect arriving with the ack is newer than any recorded one.
          if (redirect_valid) begin
            pc_d = redirect_addr;
          end else if (pend_vld_q) begin
            pc_d = pend_addr_q;
          end else begin
            pc_d = mem_addr_q + ADDR_ONE;
          end
        end else if (redirect_valid) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = redirect_addr;
        end
      end
      FETCH_DONE: begin
        state_d = FETCH_IDLE;
        if (redirect_valid) begin
          pc_d = redirect_addr;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    busy_d      = (state_d != FETCH_IDLE);
    link_addr_d = instr_pc_d + ADDR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= PC_INIT;
      instruct_q   <= '0;
      instr_pc_q   <= '0;
      link_addr_q  <= ADDR_ONE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fetch_done_q <= 1'b0;
      busy_q       <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instruct_q   <= instruct_d;
      instr_pc_q   <= instr_pc_d;
      link_addr_q  <= link_addr_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fetch_done_q <= fetch_done_d;
      busy_q       <= busy_d;
      pend_vld_q   <= pend_vld_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign fetch_done = fetch_done_q;
  assign busy       = busy_q;
  assign instruct   = instruct_q;
  assign instr_pc   = instr_pc_q;
  assign link_addr  = link_addr_q;
  assign pc         = pc_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage: holds the program counter and the instruction register, and feeds `instruct` to `control_unit`.
- `control_unit` starts a fetch with a one-cycle `fetch_start` pulse in STATE_FETCH.
- The block issues a word read over a req/ack memory handshake and latches the returned instruction. It then pulses `fetch_done` so the control unit can move to DECODE.
- It also accepts PC redirects from the jump, branch and jump-register execute states, and exports the link address for STATE_EXEC_LINK.

## Interface

- `ADDR_WIDTH`, 16: PC and memory address width, in words.
- `INSTRUCTION_WIDTH`, 16: instruction and memory data width.
- `RESET_PC`, 0: PC value after reset.

- `clk`  in  1: clock.
- `resetn`  in  1: reset, synchronous, active-low.
- `fetch_start`  in  1: fetch request pulse from the control unit.
- `fetch_done`  out  1: one-cycle pulse; `instruct` and `instr_pc` are valid.
- `busy`  out  1: high in FETCH_WAIT and FETCH_DONE.
- `instruct`  out  INSTRUCTION_WIDTH: instruction register.
- `instr_pc`  out  ADDR_WIDTH: address of the instruction held in `instruct`.
- `link_addr`  out  ADDR_WIDTH: `instr_pc + 1`, modulo 2^ADDR_WIDTH.
- `pc`  out  ADDR_WIDTH: address of the next fetch.
- `redirect_valid`  in  1: load a new PC.
- `redirect_addr`  in  ADDR_WIDTH: jump or branch target.
- `mem_req`  out  1: read request, registered.
- `mem_addr`  out  ADDR_WIDTH: read address, registered; stable while `mem_req` is high.
- `mem_ack`  in  1: read data valid; sampled only in FETCH_WAIT.
- `mem_rdata`  in  INSTRUCTION_WIDTH: read data.

## Operation

States: FETCH_IDLE, FETCH_WAIT, FETCH_DONE.

- **Reset.** State FETCH_IDLE. `pc`=RESET_PC, `instruct`=0, `instr_pc`=0, `mem_req`=0, `mem_addr`=0, `fetch_done`=0, pending redirect cleared.
- **FETCH_IDLE, `fetch_start`=1.** Set `mem_req`=1 and `mem_addr`=(`redirect_valid` ? `redirect_addr` : `pc`); go to FETCH_WAIT. A simultaneous redirect also loads `pc`.
- **FETCH_IDLE, `redirect_valid` only.** `pc` <= `redirect_addr`.
- **FETCH_WAIT, `mem_ack`=0.** Hold `mem_req` and `mem_addr`.
- **FETCH_WAIT, `mem_ack`=1.**
  - `instruct` <= `mem_rdata`, `instr_pc` <= `mem_addr`, `mem_req` <= 0.
  - `pc` <= pending ? pending_addr : `mem_addr`+1; pending is then cleared.
  - Go to FETCH_DONE.
- **FETCH_WAIT, `redirect_valid`.** Record pending_addr; it is applied at completion. The last redirect wins. A redirect in the ack cycle itself is also applied.
- **FETCH_DONE.** `fetch_done`=1; go to FETCH_IDLE. A `redirect_valid` here loads `pc` directly.
- **`fetch_start` in FETCH_WAIT or FETCH_DONE.** Ignored; no second request is queued.
- **Arithmetic.** `pc` and `link_addr` increment wraps: 0xFFFF+1 = 0x0000.
- **Reset mid-fetch.** The outstanding request is abandoned and `mem_req` is low after the reset edge. A late `mem_ack` in FETCH_IDLE is ignored.

## Timing

- `fetch_start` at cycle 0 → `mem_req` high from cycle 1.
- `mem_ack` at cycle k ≥ 1 → `instruct`, `instr_pc`, `pc` and `fetch_done` update at cycle k+1.
- Minimum fetch latency is 2 cycles. The next `fetch_start` is accepted at cycle k+2 at the earliest.
- `fetch_done` is exactly one cycle per accepted fetch.
- `instruct` is stable from `fetch_done` until the next ack.
- All outputs are registered. There is no combinational path from `mem_ack` or `mem_rdata` to any output.

## Structure

- `fetch_state_t` (FETCH_IDLE, FETCH_WAIT, FETCH_DONE) goes in `defs_pkg`, next to `state_t` and `ctrl_sig_t`.
- Add a `RESET_PC` default constant in `defs_pkg`.
- Single module, no sub-modules. The pending-redirect register (valid bit + address) stays local.

## Test plan

- **Basic fetch.** Reset, `fetch_start`, ack at cycle 1 with rdata=0x1234 → `fetch_done` at cycle 2, `instruct`=0x1234, `instr_pc`=0, `pc`=1, `link_addr`=1.
- **Wait states.** Ack delayed 5 cycles → `mem_req`/`mem_addr` held constant through cycle 5; `fetch_done` at cycle 6 only; a `fetch_start` in cycle 3 is ignored.
- **Redirect in idle and with start.** `redirect_valid` with addr=0x0040 in FETCH_IDLE → `pc`=0x0040. Redirect to 0x0080 together with `fetch_start` → `mem_addr`=0x0080; after ack, `pc`=0x0081.
- **Redirect during wait.** Redirect to 0x0200 while waiting for ack at `mem_addr`=0x0010 → `instr_pc`=0x0010, `pc`=0x0200 after completion.
- **Wrap-around.** Fetch at 0xFFFF → `pc`=0x0000, `link_addr`=0x0000.
- **Reset mid-fetch.** `resetn` low during FETCH_WAIT, then `mem_ack` after release → `mem_req`=0, `pc`=RESET_PC, `instruct` unchanged at 0, no `fetch_done`.
